// File: rtl/vdu_console_writer_if.sv
// Character input channel, display memory port and cursor/status signals of the console writer.
// The writer connects through the master modport; the surrounding system uses the slave modport.
interface vdu_console_writer_if #(
   parameter int H_CHARS = 16,
   parameter int V_CHARS = 30
);
   localparam int XW = $clog2(H_CHARS);
   localparam int YW = $clog2(V_CHARS);

   logic          i_char_valid;
   logic [7:0]    i_char;
   logic          o_char_ready;
   logic          o_mem_we;
   logic          o_mem_re;
   logic [15:0]   o_mem_addr;
   logic [7:0]    o_mem_wdata;
   logic [7:0]    i_mem_rdata;
   logic [XW-1:0] o_cursor_x;
   logic [YW-1:0] o_cursor_y;
   logic          o_busy;

   modport master (
      input  i_char_valid, i_char, i_mem_rdata,
      output o_char_ready, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata,
      output o_cursor_x, o_cursor_y, o_busy
   );

   modport slave (
      output i_char_valid, i_char, i_mem_rdata,
      input  o_char_ready, o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata,
      input  o_cursor_x, o_cursor_y, o_busy
   );
endinterface

// File: rtl/vdu_console_writer.sv
// Streams characters into a text display memory: printing, CR/LF/BS/FF handling and end-of-screen.
// Define VDU_SCROLL_EN to scroll the screen up at the bottom; otherwise the cursor wraps to row 0.
module vdu_console_writer #(
   parameter int BASE_ADDR = 'h0200,
   parameter int H_CHARS   = 16,
   parameter int V_CHARS   = 30
) (
   input logic                  i_clk,
   input logic                  i_rst,
   vdu_console_writer_if.master bus
);
   localparam int XW = $clog2(H_CHARS);
   localparam int YW = $clog2(V_CHARS);

   localparam logic [15:0]   BASE       = 16'(BASE_ADDR);
   localparam logic [15:0]   ROW_LEN    = 16'(H_CHARS);
   localparam logic [15:0]   SCREEN_END = 16'(BASE_ADDR + H_CHARS * V_CHARS - 1);
   localparam logic [XW-1:0] LAST_COL   = XW'(H_CHARS - 1);
   localparam logic [YW-1:0] LAST_ROW   = YW'(V_CHARS - 1);
   localparam logic [7:0]    SPACE      = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      PUT,
      CLR_ROW,
      CLR_ALL
`ifdef VDU_SCROLL_EN
      ,
      SCROLL_RD,
      SCROLL_WAIT,
      SCROLL_WR
`endif
   } state_t;

   // End-of-screen entry point: the first scroll read, or blanking row 0 after wrapping
`ifdef VDU_SCROLL_EN
   localparam state_t        EOS_STATE        = SCROLL_RD;
   localparam logic          EOS_WE           = 1'b0;
   localparam logic          EOS_RE           = 1'b1;
   localparam logic [15:0]   EOS_ADDR         = 16'(BASE_ADDR + H_CHARS);
   localparam logic [YW-1:0] EOS_ROW          = LAST_ROW;
   localparam logic [15:0]   CLR_ROW_START    = 16'(BASE_ADDR + (V_CHARS - 1) * H_CHARS);
   localparam logic [15:0]   SCROLL_LAST_DEST = SCREEN_END - ROW_LEN;
`else
   localparam state_t        EOS_STATE        = CLR_ROW;
   localparam logic          EOS_WE           = 1'b1;
   localparam logic          EOS_RE           = 1'b0;
   localparam logic [15:0]   EOS_ADDR         = BASE;
   localparam logic [YW-1:0] EOS_ROW          = '0;
   localparam logic [15:0]   CLR_ROW_START    = BASE;
`endif
   localparam logic [15:0]   CLR_ROW_END      = CLR_ROW_START + ROW_LEN - 16'd1;

   state_t        state;
   logic [XW-1:0] cursor_x;
   logic [YW-1:0] cursor_y;
   logic          mem_we;
   logic          mem_re;
   logic [15:0]   mem_addr;
   logic [7:0]    mem_wdata;
   logic          advance;

   logic          printable;
   logic [7:0]    display_code;
   logic [15:0]   cell_addr;

`ifndef VDU_SCROLL_EN
   logic          unused_rdata;
   assign unused_rdata = ^bus.i_mem_rdata;
`endif

   // Lower-case folds onto upper-case; bit 5 of the code is set only for the 'h20-'h3F block
   assign printable    = bus.i_char[6:0] >= 7'h20;
   assign display_code = {bus.i_char[7], 1'b0, bus.i_char[6:5] == 2'b01, bus.i_char[4:0]};
   assign cell_addr    = BASE + 16'(cursor_y) * ROW_LEN + 16'(cursor_x);

   assign bus.o_char_ready = (state == IDLE) && !i_rst;
   assign bus.o_busy       = state != IDLE;
   assign bus.o_mem_we     = mem_we;
   assign bus.o_mem_re     = mem_re;
   assign bus.o_mem_addr   = mem_addr;
   assign bus.o_mem_wdata  = mem_wdata;
   assign bus.o_cursor_x   = cursor_x;
   assign bus.o_cursor_y   = cursor_y;

   // All memory port outputs are registered and set up one state ahead of the cycle they appear in
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         cursor_x  <= '0;
         cursor_y  <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         advance   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_char_valid) begin
                  advance <= 1'b0;
                  state   <= PUT;
                  if (printable) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= cell_addr;
                     mem_wdata <= display_code;
                     advance   <= 1'b1;
                  end else begin
                     case (bus.i_char)
                        8'h0D: cursor_x <= '0;
                        8'h0A: begin
                           if (cursor_y != LAST_ROW) begin
                              cursor_y <= cursor_y + 1'b1;
                           end else begin
                              state     <= EOS_STATE;
                              mem_we    <= EOS_WE;
                              mem_re    <= EOS_RE;
                              mem_addr  <= EOS_ADDR;
                              mem_wdata <= SPACE;
                              cursor_y  <= EOS_ROW;
                           end
                        end
                        8'h08: begin
                           if (cursor_x != '0) begin
                              cursor_x  <= cursor_x - 1'b1;
                              mem_we    <= 1'b1;
                              mem_addr  <= cell_addr - 16'd1;
                              mem_wdata <= SPACE;
                           end
                        end
                        8'h0C: begin
                           state     <= CLR_ALL;
                           mem_we    <= 1'b1;
                           mem_addr  <= BASE;
                           mem_wdata <= SPACE;
                        end
                        default: ;
                     endcase
                  end
               end
            end

            PUT: begin
               mem_we <= 1'b0;
               state  <= IDLE;
               if (advance) begin
                  if (cursor_x != LAST_COL) begin
                     cursor_x <= cursor_x + 1'b1;
                  end else begin
                     cursor_x <= '0;
                     if (cursor_y != LAST_ROW) begin
                        cursor_y <= cursor_y + 1'b1;
                     end else begin
                        state     <= EOS_STATE;
                        mem_we    <= EOS_WE;
                        mem_re    <= EOS_RE;
                        mem_addr  <= EOS_ADDR;
                        mem_wdata <= SPACE;
                        cursor_y  <= EOS_ROW;
                     end
                  end
               end
            end

            CLR_ALL: begin
               if (mem_addr == SCREEN_END) begin
                  mem_we   <= 1'b0;
                  state    <= IDLE;
                  cursor_x <= '0;
                  cursor_y <= '0;
               end else begin
                  mem_addr <= mem_addr + 16'd1;
               end
            end

            CLR_ROW: begin
               if (mem_addr == CLR_ROW_END) begin
                  mem_we <= 1'b0;
                  state  <= IDLE;
               end else begin
                  mem_addr <= mem_addr + 16'd1;
               end
            end

`ifdef VDU_SCROLL_EN
            // Read data returns during SCROLL_WAIT, so it is captured on the edge leaving it
            SCROLL_RD: begin
               mem_re <= 1'b0;
               state  <= SCROLL_WAIT;
            end

            SCROLL_WAIT: begin
               mem_we    <= 1'b1;
               mem_addr  <= mem_addr - ROW_LEN;
               mem_wdata <= bus.i_mem_rdata;
               state     <= SCROLL_WR;
            end

            SCROLL_WR: begin
               if (mem_addr == SCROLL_LAST_DEST) begin
                  mem_addr  <= CLR_ROW_START;
                  mem_wdata <= SPACE;
                  state     <= CLR_ROW;
               end else begin
                  mem_we   <= 1'b0;
                  mem_re   <= 1'b1;
                  mem_addr <= mem_addr + ROW_LEN + 16'd1;
                  state    <= SCROLL_RD;
               end
            end
`endif

            default: begin
               mem_we <= 1'b0;
               mem_re <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vdu_console_writer.sv
// Self-checking bench for vdu_console_writer: a cycle-level expectation queue built from the character
// rules, a backing display memory, and directed character sequences with hand-computed results.
`timescale 1ns/1ps
module tb_vdu_console_writer;
   localparam int BASE = 'h0200;
   localparam int H    = 16;
   localparam int V    = 30;

   typedef struct packed {
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [7:0]  data;
   } op_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;

   vdu_console_writer_if #(.H_CHARS(H), .V_CHARS(V)) bus ();

   vdu_console_writer #(.BASE_ADDR(BASE), .H_CHARS(H), .V_CHARS(V)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus(bus)
   );

   always #5 i_clk = ~i_clk;

   logic [7:0] mem    [0:65535];
   logic [7:0] shadow [0:65535];
   op_t        expQ[$];
   int         modelX = 0;
   int         modelY = 0;
   int         errors = 0;
   int         checks = 0;
   int         busyCount = 0;
   int         writeCount = 0;
   int         readCount = 0;

   // Display memory: synchronous write, read data one cycle after the read strobe, junk otherwise
   always @(posedge i_clk) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      bus.i_mem_rdata <= bus.o_mem_re ? mem[bus.o_mem_addr] : 8'hEE;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] displayCode(input logic [7:0] c);
      int v;
      v = int'(c[6:0]);
      if (v >= 'h60) v = v - 'h20;
      v = v % 64;
      if (c[7]) v = v + 128;
      return 8'(v);
   endfunction

   task automatic pushWrite(input int addr, input logic [7:0] data);
      op_t o;
      o.we = 1'b1; o.re = 1'b0; o.addr = 16'(addr); o.data = data;
      expQ.push_back(o);
      shadow[16'(addr)] = data;
   endtask

   task automatic pushRead(input int addr);
      op_t o;
      o.we = 1'b0; o.re = 1'b1; o.addr = 16'(addr); o.data = 8'h00;
      expQ.push_back(o);
   endtask

   task automatic pushIdle();
      op_t o;
      o = '0;
      expQ.push_back(o);
   endtask

   task automatic modelEndOfScreen();
`ifdef VDU_SCROLL_EN
      for (int a = BASE + H; a < BASE + H * V; a++) begin
         pushRead(a);
         pushIdle();
         pushWrite(a - H, shadow[16'(a)]);
      end
      for (int c = 0; c < H; c++) pushWrite(BASE + (V - 1) * H + c, 8'h20);
`else
      modelY = 0;
      for (int c = 0; c < H; c++) pushWrite(BASE + c, 8'h20);
`endif
   endtask

   // Every accepted character appends the bus activity of the cycles that follow its acceptance
   task automatic modelAccept(input logic [7:0] c);
      if (c[6:0] >= 7'h20) begin
         pushWrite(BASE + modelY * H + modelX, displayCode(c));
         modelX++;
         if (modelX == H) begin
            modelX = 0;
            if (modelY < V - 1) modelY++;
            else modelEndOfScreen();
         end
      end else if (c == 8'h0D) begin
         pushIdle();
         modelX = 0;
      end else if (c == 8'h0A) begin
         if (modelY < V - 1) begin
            pushIdle();
            modelY++;
         end else begin
            modelEndOfScreen();
         end
      end else if (c == 8'h08) begin
         if (modelX > 0) begin
            modelX--;
            pushWrite(BASE + modelY * H + modelX, 8'h20);
         end else begin
            pushIdle();
         end
      end else if (c == 8'h0C) begin
         for (int i = 0; i < H * V; i++) pushWrite(BASE + i, 8'h20);
         modelX = 0;
         modelY = 0;
      end else begin
         pushIdle();
      end
   endtask

   always @(posedge i_clk) begin
      if (!i_rst && bus.i_char_valid && bus.o_char_ready) modelAccept(bus.i_char);
   end

   always @(negedge i_clk) begin : compareProc
      op_t e;
      if (!i_rst) begin
         if (bus.o_busy === 1'b1) busyCount++;
         if (bus.o_mem_we === 1'b1) writeCount++;
         if (bus.o_mem_re === 1'b1) readCount++;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cyc_busy", 32'(bus.o_busy), 32'd1);
            checkOutput("cyc_ready", 32'(bus.o_char_ready), 32'd0);
            checkOutput("cyc_we", 32'(bus.o_mem_we), 32'(e.we));
            checkOutput("cyc_re", 32'(bus.o_mem_re), 32'(e.re));
            if (e.we || e.re) checkOutput("cyc_addr", 32'(bus.o_mem_addr), 32'(e.addr));
            if (e.we) checkOutput("cyc_wdata", 32'(bus.o_mem_wdata), 32'(e.data));
         end else begin
            checkOutput("idle_busy", 32'(bus.o_busy), 32'd0);
            checkOutput("idle_ready", 32'(bus.o_char_ready), 32'd1);
            checkOutput("idle_we", 32'(bus.o_mem_we), 32'd0);
            checkOutput("idle_re", 32'(bus.o_mem_re), 32'd0);
            checkOutput("idle_cursor_x", 32'(bus.o_cursor_x), 32'(modelX));
            checkOutput("idle_cursor_y", 32'(bus.o_cursor_y), 32'(modelY));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] c);
      int n;
      n = 0;
      @(negedge i_clk);
      while (!(bus.o_char_ready === 1'b1 && expQ.size() == 0) && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout: got ready=%0b, expected 1 within 5000 cycles", bus.o_char_ready);
      end
      bus.i_char_valid = 1'b1;
      bus.i_char       = c;
      @(negedge i_clk);
      bus.i_char_valid = 1'b0;
      bus.i_char       = 8'h00;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while ((expQ.size() != 0 || bus.o_busy !== 1'b0) && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got busy=%0b, expected idle within 5000 cycles", name, bus.o_busy);
      end
      @(negedge i_clk);
   endtask

   task automatic resetDut();
      i_rst = 1'b1;
      expQ.delete();
      modelX = 0;
      modelY = 0;
      bus.i_char_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      checkOutput("rst_ready", 32'(bus.o_char_ready), 32'd0);
      checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
      checkOutput("rst_we", 32'(bus.o_mem_we), 32'd0);
      checkOutput("rst_re", 32'(bus.o_mem_re), 32'd0);
      checkOutput("rst_addr", 32'(bus.o_mem_addr), 32'd0);
      checkOutput("rst_wdata", 32'(bus.o_mem_wdata), 32'd0);
      checkOutput("rst_cursor_x", 32'(bus.o_cursor_x), 32'd0);
      checkOutput("rst_cursor_y", 32'(bus.o_cursor_y), 32'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
   endtask

   function automatic int countNot(input int first, input int count, input logic [7:0] value);
      int bad;
      bad = 0;
      for (int a = first; a < first + count; a++) if (mem[16'(a)] !== value) bad++;
      return bad;
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int b0, w0, r0;
      for (int a = 0; a < 65536; a++) begin
         mem[a]    = 8'h00;
         shadow[a] = 8'h00;
      end
      bus.i_char_valid = 1'b0;
      bus.i_char       = 8'h00;
      #1;
      resetDut();

      // 'A' lands at the first cell as code 'h01, ready returns two cycles after acceptance
      w0 = writeCount;
      applyStimulus(8'h41);
      checkOutput("A_ready_n1", 32'(bus.o_char_ready), 32'd0);
      @(negedge i_clk);
      checkOutput("A_ready_n2", 32'(bus.o_char_ready), 32'd1);
      waitIdle("A");
      checkOutput("A_mem", 32'(mem[16'h0200]), 32'h01);
      checkOutput("A_writes", 32'(writeCount - w0), 32'd1);
      checkOutput("A_cursor_x", 32'(bus.o_cursor_x), 32'd1);
      checkOutput("A_cursor_y", 32'(bus.o_cursor_y), 32'd0);

      // Form feed blanks 'h0200-'h03DF, one write per busy cycle
      b0 = busyCount; w0 = writeCount;
      applyStimulus(8'h0C);
      waitIdle("FF");
      checkOutput("FF_busy", 32'(busyCount - b0), 32'd480);
      checkOutput("FF_writes", 32'(writeCount - w0), 32'd480);
      checkOutput("FF_fill", 32'(countNot('h0200, 480, 8'h20)), 32'd0);
      checkOutput("FF_cursor_x", 32'(bus.o_cursor_x), 32'd0);
      checkOutput("FF_cursor_y", 32'(bus.o_cursor_y), 32'd0);

      // Sixteen inverse 'z' fill row 0 and wrap the cursor onto row 1
      for (int i = 0; i < 16; i++) applyStimulus(8'hFA);
      waitIdle("z_row");
      checkOutput("z_row_fill", 32'(countNot('h0200, 16, 8'h9A)), 32'd0);
      checkOutput("z_cursor_x", 32'(bus.o_cursor_x), 32'd0);
      checkOutput("z_cursor_y", 32'(bus.o_cursor_y), 32'd1);

      // Backspace, CR, ignored control, LF, folded and inverse printables
      applyStimulus(8'h48);
      applyStimulus(8'h49);
      applyStimulus(8'h08);
      applyStimulus(8'h08);
      applyStimulus(8'h08);
      applyStimulus(8'h0D);
      applyStimulus(8'h07);
      applyStimulus(8'h0A);
      applyStimulus(8'h7E);
      applyStimulus(8'hA0);
      waitIdle("misc");
      checkOutput("bs_cell0", 32'(mem[16'h0210]), 32'h20);
      checkOutput("bs_cell1", 32'(mem[16'h0211]), 32'h20);
      checkOutput("tilde_code", 32'(mem[16'h0220]), 32'h1E);
      checkOutput("inv_space", 32'(mem[16'h0221]), 32'hA0);
      checkOutput("misc_cursor_x", 32'(bus.o_cursor_x), 32'd2);
      checkOutput("misc_cursor_y", 32'(bus.o_cursor_y), 32'd2);

      // Row 1 filled with 'h05, cursor walked to the last row, then one more line feed
      applyStimulus(8'h0C);
      applyStimulus(8'h0A);
      for (int i = 0; i < 16; i++) applyStimulus(8'h45);
      for (int i = 0; i < 27; i++) applyStimulus(8'h0A);
      waitIdle("to_bottom");
      checkOutput("bottom_cursor_y", 32'(bus.o_cursor_y), 32'd29);
      b0 = busyCount; r0 = readCount;
      applyStimulus(8'h0A);
      waitIdle("eos");
`ifdef VDU_SCROLL_EN
      checkOutput("scroll_busy", 32'(busyCount - b0), 32'(464 * 3 + 16));
      checkOutput("scroll_reads", 32'(readCount - r0), 32'd464);
      checkOutput("scroll_row0", 32'(countNot('h0200, 16, 8'h05)), 32'd0);
      checkOutput("scroll_row29", 32'(countNot('h03D0, 16, 8'h20)), 32'd0);
      checkOutput("scroll_cursor_x", 32'(bus.o_cursor_x), 32'd0);
      checkOutput("scroll_cursor_y", 32'(bus.o_cursor_y), 32'd29);
`else
      checkOutput("wrap_busy", 32'(busyCount - b0), 32'd16);
      checkOutput("wrap_reads", 32'(readCount - r0), 32'd0);
      checkOutput("wrap_row0", 32'(countNot('h0200, 16, 8'h20)), 32'd0);
      checkOutput("wrap_row1", 32'(countNot('h0210, 16, 8'h05)), 32'd0);
      checkOutput("wrap_cursor_x", 32'(bus.o_cursor_x), 32'd0);
      checkOutput("wrap_cursor_y", 32'(bus.o_cursor_y), 32'd0);
`endif

      // Reset in the middle of a form feed aborts at once; 'B' then starts from (0,0)
      applyStimulus(8'h0C);
      repeat (100) @(negedge i_clk);
      @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      expQ.delete();
      modelX = 0;
      modelY = 0;
      @(posedge i_clk);
      #1;
      checkOutput("abort_we", 32'(bus.o_mem_we), 32'd0);
      checkOutput("abort_busy", 32'(bus.o_busy), 32'd0);
      checkOutput("abort_ready", 32'(bus.o_char_ready), 32'd0);
      checkOutput("abort_cursor_x", 32'(bus.o_cursor_x), 32'd0);
      checkOutput("abort_cursor_y", 32'(bus.o_cursor_y), 32'd0);
      #1 i_rst = 1'b0;
      applyStimulus(8'h42);
      waitIdle("B");
      checkOutput("B_mem", 32'(mem[16'h0200]), 32'h02);
      checkOutput("B_cursor_x", 32'(bus.o_cursor_x), 32'd1);
      checkOutput("B_cursor_y", 32'(bus.o_cursor_y), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
